instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch reader on the consumer side of the PC's address stream.
//  - Accepts PC values over a valid/ready handshake and issues one read per address to instruction memory.
//  - Buffers returned words with their PC in a show-ahead FIFO for decode.
//  - flush (taken PCsrc) discards every buffered word and any in-flight response.
// PARAMETERS
//  AW     8   address / PC width
//  IW     16  instruction word width
//  DEPTH  4   FIFO entries, power of two, >= 2
// PORTS
//  CLK        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  pc         in   AW  fetch address from PC
//  pc_valid   in   1   pc is valid
//  pc_ready   out  1   address accepted this cycle when pc_valid && pc_ready
//  flush      in   1   redirect: drop buffered and in-flight fetches
//  mem_req    out  1   memory read request, held until mem_ack
//  mem_addr   out  AW  read address, stable while mem_req = 1
//  mem_ack    in   1   mem_rdata valid; completes the request
//  mem_rdata  in   IW  instruction word
//  instr      out  IW  head-of-FIFO instruction
//  instr_pc   out  AW  PC of head instruction
//  instr_val  out  1   FIFO non-empty
//  instr_rdy  in   1   decode consumes head when instr_val && instr_rdy
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - State = IDLE.
//    - FIFO empty; instr_val = 0, instr = 0, instr_pc = 0.
//    - mem_req = 0, mem_addr = 0, pc_ready = 0 while reset is asserted.
//  - FSM states: IDLE, WAIT, DRAIN. At most one request outstanding.
//  - pc_ready = (state == IDLE) && !flush && (count < DEPTH). Combinational.
//    - count includes an entry popped in the same cycle; no pop-bypass.
//  - IDLE, pc_valid && pc_ready:
//    - Next edge: mem_req <= 1, mem_addr <= pc, state -> WAIT.
//  - WAIT, mem_ack && !flush:
//    - Push {mem_addr, mem_rdata}.
//    - mem_req <= 0; state -> IDLE.
//    - Earliest re-issue is the next cycle, so peak throughput is 1 fetch per 2 cycles.
//  - mem_ack is ignored unless mem_req = 1. It is legal on the first cycle mem_req is high.
//  - FIFO space reservation: a request is issued only when count < DEPTH, so a push never hits a full FIFO.
//    - Simultaneous push and pop: count unchanged, head advances.
//  - Pop: instr_val && instr_rdy -> read pointer advances next edge.
//    - instr / instr_pc are driven directly from the head entry (0 latency, show-ahead).
//  - Pointers wrap modulo DEPTH. count has width $clog2(DEPTH)+1.
//  - flush (highest priority, takes effect at the next edge):
//    - FIFO cleared: count = 0, pointers = 0, instr_val = 0 the next cycle. A same-cycle pop is irrelevant.
//    - IDLE: stay IDLE; pc_ready = 0 during the flush cycle.
//    - WAIT, no mem_ack: -> DRAIN. mem_req stays high until ack; the response is discarded.
//    - WAIT or DRAIN, with mem_ack in the same cycle: response discarded, mem_req <= 0, -> IDLE.
//  - DRAIN, mem_ack: discard, mem_req <= 0, -> IDLE. pc_ready = 0 throughout DRAIN.
//  - Reset mid-operation: all state is lost immediately. The pending request is abandoned (mem_req drops asynchronously).
// TESTING
//  1 Reset:
//    - Stimulus: reset = 0 mid-WAIT.
//    - Response: mem_req = 0, instr_val = 0 at once; after release, IDLE with pc_ready = 1.
//  2 Basic fetch:
//    - Stimulus: pc = 8'h10 accepted; memory acks 2 cycles later with 16'hA5A5.
//    - Response: instr_val = 1 the cycle after ack, instr = 16'hA5A5, instr_pc = 8'h10.
//  3 Fill:
//    - Stimulus: instr_rdy = 0; feed pc 8'h00..8'h05 with immediate ack.
//    - Response: exactly 4 fetches complete; pc_ready = 0 with count = 4.
//    - Then one pop re-enables pc_ready; pops return in order 8'h00..8'h03.
//  4 Flush in flight:
//    - Stimulus: issue pc = 8'h20; flush in the first WAIT cycle; ack 3 cycles later.
//    - Response: DRAIN; nothing pushed; pc_ready = 1 the cycle after ack; next pc = 8'h30 fetches normally.
//  5 Flush with ack:
//    - Stimulus: flush and mem_ack in the same cycle, FIFO holding 2 entries.
//    - Response: FIFO empty and IDLE next cycle; no word pushed.
//  6 Wrap:
//    - Stimulus: 20 fetches with instr_rdy = 1 and random ack delay 0-3.
//    - Response: in-order instr_pc/instr match a scoreboard; pointers wrap without loss.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch reader: accepts PCs, issues one memory read per address,
// and buffers {pc, word} pairs in a show-ahead FIFO for decode. flush drops both.
module instr_fetch #(
  parameter int AW    = 8,
  parameter int IW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_val,
  input  logic          instr_rdy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_next_s;
  logic [CW-1:0] count_r;
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [AW-1:0] pc_mem_r   [DEPTH];
  logic [IW-1:0] data_mem_r [DEPTH];
  logic          ack_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;

  // count includes the entry being popped this cycle, so a full FIFO blocks issue
  // even while decode is draining it; this keeps a landing slot reserved per request.
  assign pc_ready  = reset && (state_r == IDLE) && !flush && (count_r < FULL_CNT);
  assign ack_s     = mem_req && mem_ack;
  assign accept_s  = pc_valid && pc_ready;
  assign push_s    = (state_r == WAIT) && ack_s && !flush;
  assign instr_val = (count_r != {CW{1'b0}});
  assign pop_s     = instr_val && instr_rdy;
  assign instr     = data_mem_r[rptr_r];
  assign instr_pc  = pc_mem_r[rptr_r];

  // Next-state selection for the single-outstanding-request fetch FSM
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = WAIT;
        else          state_next_s = IDLE;
      end
      WAIT: begin
        if (ack_s)      state_next_s = IDLE;
        else if (flush) state_next_s = DRAIN;
        else            state_next_s = WAIT;
      end
      DRAIN: begin
        if (ack_s) state_next_s = IDLE;
        else       state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state and memory request registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= {AW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        mem_req  <= 1'b1;
        mem_addr <= pc;
      end else if (ack_s) begin
        mem_req <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; flush overrides any same-cycle push or pop
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) wptr_r <= wptr_r + PW'(1);
      if (pop_s)  rptr_r <= rptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage of fetched words tagged with their PC
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= {AW{1'b0}};
        data_mem_r[i] <= {IW{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_r[wptr_r]   <= mem_addr;
      data_mem_r[wptr_r] <= mem_rdata;
    end
  end

endmodule
